// File: rtl/arm_serial_rx.sv
// ---------------------------------------------------------------------------
// arm_serial_rx
//   Far-end receiver for the serial out-buffer link. The InD/InC pair is
//   oversampled on the local clk_in, which must run at least 4x the InC toggle
//   rate. The receiver rebuilds the frame {start=0, A, ack, D, ack, stop=0},
//   MSB first, and then presents A/D in parallel with a one-cycle Valid strobe.
//   Rejected frames raise a one-cycle FrameErr pulse instead.
//
// Ports
//   clk_in    in   1      local sampling clock
//   reset_n   in   1      reset, asynchronous, active-HIGH (legacy name kept)
//   InD       in   1      serial data; ack slots may float
//   InC       in   1      serial clock, idles low
//   A_out     out  sizeA  address of last good frame
//   D_out     out  sizeD  data of last good frame
//   Valid     out  1      pulse: A_out/D_out updated this cycle
//   FrameErr  out  1      pulse: frame rejected (start/stop bit or timeout)
//   Busy      out  1      frame in progress
// ---------------------------------------------------------------------------

// Plain flop chain used as a synchronizer. InD and InC each get an identical
// chain, so a data bit and its clock edge stay aligned cycle-for-cycle.
module arm_serial_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_in,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk_in or posedge reset_n) begin
    if (reset_n) chain_q <= '0;
    else         chain_q <= {chain_q[STAGES-2:0], d_i};
  end

  assign q_o = chain_q[STAGES-1];
endmodule

module arm_serial_rx #(
  parameter int sizeA       = 7,
  parameter int sizeD       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             InD,
  input  logic             InC,
  output logic [sizeA-1:0] A_out,
  output logic [sizeD-1:0] D_out,
  output logic             Valid,
  output logic             FrameErr,
  output logic             Busy
);
  localparam int FRAME_LEN = sizeA + sizeD + 4;
  localparam int CNT_W     = $clog2(FRAME_LEN) + 1;
  localparam int TO_W      = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RECV, CHECK, ERR} state_t;

  // ---- input synchronizers: lane 0 = InD, lane 1 = InC ----
  logic [1:0] raw_in, sync_in;
  assign raw_in = {InC, InD};

  for (genvar g = 0; g < 2; g++) begin : g_sync
    arm_serial_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk_in  (clk_in),
      .reset_n (reset_n),
      .d_i     (raw_in[g]),
      .q_o     (sync_in[g])
    );
  end

  logic sync_d, sync_c;
  assign sync_d = sync_in[0];
  assign sync_c = sync_in[1];

  // ---- state ----
  state_t                 state_q;
  logic                   syncc_prev_q;
  logic [FRAME_LEN-1:0]   sr_q;
  logic [CNT_W-1:0]       bcnt_q;
  logic [TO_W-1:0]        to_q;
  logic [sizeA-1:0]       a_q;
  logic [sizeD-1:0]       d_q;
  logic                   valid_q, ferr_q, busy_q;

  logic                   rise;
  logic [FRAME_LEN-1:0]   sr_d;
  logic                   frame_ok;

  assign rise     = sync_c & ~syncc_prev_q;
  assign sr_d     = {sr_q[FRAME_LEN-2:0], sync_d};
  // Ack slots (sr[sizeD+2] and sr[1]) are never looked at, so a floating
  // line during the acknowledge windows cannot reach the outputs.
  assign frame_ok = ~sr_q[FRAME_LEN-1] & ~sr_q[0];

  always_ff @(posedge clk_in or posedge reset_n) begin
    if (reset_n) begin
      state_q      <= IDLE;
      syncc_prev_q <= 1'b0;
      sr_q         <= '0;
      bcnt_q       <= '0;
      to_q         <= '0;
      a_q          <= '0;
      d_q          <= '0;
      valid_q      <= 1'b0;
      ferr_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      syncc_prev_q <= sync_c;
      valid_q      <= 1'b0;
      ferr_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          // First edge of a frame carries the start bit.
          if (rise) begin
            sr_q    <= sr_d;
            bcnt_q  <= CNT_W'(1);
            to_q    <= '0;
            state_q <= RECV;
            busy_q  <= 1'b1;
          end
        end
        RECV: begin
          // An edge in the same cycle as the timeout wins: the frame goes on.
          if (rise) begin
            sr_q   <= sr_d;
            bcnt_q <= bcnt_q + CNT_W'(1);
            to_q   <= '0;
            if (bcnt_q == CNT_W'(FRAME_LEN - 1)) begin
              state_q <= CHECK;
              busy_q  <= 1'b0;
            end
          end else if (to_q == TO_W'(TIMEOUT - 1)) begin
            to_q    <= '0;
            state_q <= ERR;
            busy_q  <= 1'b0;
          end else begin
            to_q <= to_q + TO_W'(1);
          end
        end
        CHECK: begin
          if (frame_ok) begin
            a_q     <= sr_q[FRAME_LEN-2 -: sizeA];
            d_q     <= sr_q[sizeD+1:2];
            valid_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            state_q <= ERR;
          end
          bcnt_q <= '0;
        end
        ERR: begin
          ferr_q  <= 1'b1;
          bcnt_q  <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign A_out    = a_q;
  assign D_out    = d_q;
  assign Valid    = valid_q;
  assign FrameErr = ferr_q;
  assign Busy     = busy_q;
endmodule

// File: tb/tb_arm_serial_rx.sv
module tb_arm_serial_rx;
  logic       clk_in = 1'b0;
  logic       reset_n;
  logic       InD, InC;
  logic [6:0] A_out;
  logic [7:0] D_out;
  logic       Valid, FrameErr, Busy;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       err;
    logic [6:0] a;
    logic [7:0] d;
  } exp_t;

  exp_t exp_q[$];

  arm_serial_rx dut (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .InD      (InD),
    .InC      (InC),
    .A_out    (A_out),
    .D_out    (D_out),
    .Valid    (Valid),
    .FrameErr (FrameErr),
    .Busy     (Busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per Valid/FrameErr pulse.
  always @(negedge clk_in) begin
    if (!reset_n) begin
      if (Valid && FrameErr) chk("valid_and_err_together", 1, 0);
      if (Valid || FrameErr) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {30'd0, Valid, FrameErr}, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pulse_kind", {30'd0, Valid, FrameErr}, e.err ? 32'd1 : 32'd2);
          chk("A_out", {25'd0, A_out}, {25'd0, e.a});
          chk("D_out", {24'd0, D_out}, {24'd0, e.d});
        end
      end
    end
  end

  // Frame bits MSB first: {start, A, ack, D, ack, stop}. InD changes while
  // InC is low; InC is high for `half` cycles and low for `half` cycles.
  task automatic send_frame(input logic [6:0] a, input logic [7:0] d,
                            input logic sbit, input logic pbit,
                            input bit ackx, input int nbits, input int half);
    logic [18:0] f;
    f = {sbit, a, 1'b0, d, 1'b0, pbit};
    for (int i = 18; i > 18 - nbits; i--) begin
      @(negedge clk_in);
      InD = f[i];
      if (ackx && i == 10) InD = 1'bx;
      if (ackx && i == 1)  InD = 1'bz;
      repeat (half - 1) @(negedge clk_in);
      InC = 1'b1;
      repeat (half) @(negedge clk_in);
      InC = 1'b0;
    end
  endtask

  initial begin
    int waited;
    reset_n = 1'b1;
    InD = 1'b0;
    InC = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("rst_A", {25'd0, A_out}, 0);
    chk("rst_D", {24'd0, D_out}, 0);
    chk("rst_flags", {29'd0, Valid, FrameErr, Busy}, 0);
    reset_n = 1'b0;
    repeat (3) @(negedge clk_in);

    // 1: basic frame, period 8
    exp_q.push_back('{1'b0, 7'h55, 8'hA3});
    send_frame(7'h55, 8'hA3, 0, 0, 0, 5, 4);
    chk("busy_mid_frame", {31'd0, Busy}, 1);
    send_frame(7'h55, 8'hA3, 0, 0, 0, 0, 4);
    // restart not allowed mid-frame; send remaining bits instead
    begin
      logic [18:0] f;
      f = {1'b0, 7'h55, 1'b0, 8'hA3, 1'b0, 1'b0};
      for (int i = 13; i >= 0; i--) begin
        @(negedge clk_in); InD = f[i];
        repeat (3) @(negedge clk_in); InC = 1'b1;
        repeat (4) @(negedge clk_in); InC = 1'b0;
      end
    end
    repeat (10) @(negedge clk_in);

    // 2: floating ack slots
    exp_q.push_back('{1'b0, 7'h7F, 8'h00});
    send_frame(7'h7F, 8'h00, 0, 0, 1, 19, 4);
    repeat (10) @(negedge clk_in);

    // 3: bad start bit, then bad stop bit; outputs hold 7F/00
    exp_q.push_back('{1'b1, 7'h7F, 8'h00});
    send_frame(7'h01, 8'h01, 1, 0, 0, 19, 4);
    repeat (10) @(negedge clk_in);
    exp_q.push_back('{1'b1, 7'h7F, 8'h00});
    send_frame(7'h01, 8'h01, 0, 1, 0, 19, 4);
    repeat (10) @(negedge clk_in);
    chk("hold_A_after_err", {25'd0, A_out}, 32'h7F);
    chk("hold_D_after_err", {24'd0, D_out}, 32'h00);

    // 4: InC stalls after 10 bits -> timeout, then a good frame
    exp_q.push_back('{1'b1, 7'h7F, 8'h00});
    send_frame(7'h12, 8'h34, 0, 0, 0, 10, 4);
    chk("busy_before_timeout", {31'd0, Busy}, 1);
    repeat (70) @(negedge clk_in);
    chk("busy_after_timeout", {31'd0, Busy}, 0);
    exp_q.push_back('{1'b0, 7'h12, 8'h34});
    send_frame(7'h12, 8'h34, 0, 0, 0, 19, 4);
    repeat (10) @(negedge clk_in);

    // 5: reset at bit 12
    send_frame(7'h55, 8'hAA, 0, 0, 0, 12, 4);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_in);
    chk("midrst_A", {25'd0, A_out}, 0);
    chk("midrst_D", {24'd0, D_out}, 0);
    chk("midrst_flags", {29'd0, Valid, FrameErr, Busy}, 0);
    reset_n = 1'b0;
    repeat (3) @(negedge clk_in);
    exp_q.push_back('{1'b0, 7'h3C, 8'hC3});
    send_frame(7'h3C, 8'hC3, 0, 0, 0, 19, 4);
    repeat (10) @(negedge clk_in);

    // 6: back-to-back frames at the fastest InC rate (period 4)
    exp_q.push_back('{1'b0, 7'h01, 8'h02});
    exp_q.push_back('{1'b0, 7'h03, 8'h04});
    send_frame(7'h01, 8'h02, 0, 0, 0, 19, 2);
    send_frame(7'h03, 8'h04, 0, 0, 0, 19, 2);

    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      @(negedge clk_in);
      waited++;
    end
    chk("pending_expectations", exp_q.size(), 0);
    repeat (5) @(negedge clk_in);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
